// File: rtl/machine_ctl.sv
// Instruction-cycle controller for the 8-phase CPU: aligns an 8-step sequencer
// to the clock generator's fetch strobe and decodes registered datapath strobes.
module machine_ctl #(
    parameter bit RESYNC_EN  = 1'b1,
    parameter bit WAIT_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       load_acc,
    output logic       rd,
    output logic       wr,
    output logic       load_ir,
    output logic       datactl_ena,
    output logic       halt,
    output logic [2:0] step,
    output logic       running,
    output logic       sync_err
);

    // state  | meaning
    // IDLE   | waiting for alignment to fetch after reset
    // RUN    | sequencer stepping 0..7, strobes decoded per step
    // HALTED | HLT executed; only halt asserted until reset
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Strobe vector bit positions
    localparam int B_INC_PC   = 7;
    localparam int B_LOAD_PC  = 6;
    localparam int B_LOAD_ACC = 5;
    localparam int B_RD       = 4;
    localparam int B_WR       = 3;
    localparam int B_LOAD_IR  = 2;
    localparam int B_DATACTL  = 1;
    localparam int B_HALT     = 0;

    localparam logic [7:0] STRB_HALTED = 8'b0000_0001;

    state_t     state, state_nxt;
    logic [2:0] step_r, step_nxt;
    logic       fetch_q;
    logic       rise;
    logic       err_r, err_nxt;
    logic [7:0] strb_r, strb_nxt;

    function automatic logic [7:0] decode(input logic [2:0] s,
                                          input logic [2:0] op,
                                          input logic       z);
        logic [7:0] v;
        logic       alu;
        v   = '0;
        alu = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
        case (s)
            3'd0: begin
                v[B_RD]      = 1'b1;
                v[B_LOAD_IR] = 1'b1;
            end
            3'd1: begin
                v[B_INC_PC]  = 1'b1;
                v[B_RD]      = 1'b1;
                v[B_LOAD_IR] = 1'b1;
            end
            3'd2: v = '0;
            3'd3: begin
                v[B_INC_PC] = 1'b1;
                v[B_HALT]   = (op == OP_HLT);
            end
            3'd4: begin
                v[B_RD]      = alu;
                v[B_DATACTL] = (op == OP_STO);
                v[B_LOAD_PC] = (op == OP_JMP);
            end
            3'd5: begin
                v[B_RD]       = alu;
                v[B_LOAD_ACC] = alu;
                v[B_DATACTL]  = (op == OP_STO);
                v[B_WR]       = (op == OP_STO);
                v[B_LOAD_PC]  = (op == OP_JMP);
                v[B_INC_PC]   = (op == OP_JMP) || ((op == OP_SKZ) && z);
            end
            3'd6: begin
                v[B_RD]      = alu;
                v[B_DATACTL] = (op == OP_STO);
            end
            3'd7: v[B_INC_PC] = (op == OP_SKZ) && z;
            default: v = '0;
        endcase
        return v;
    endfunction

    assign rise = fetch & ~fetch_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            step_r  <= 3'd0;
            fetch_q <= 1'b0;
            err_r   <= 1'b0;
            strb_r  <= '0;
        end else begin
            state   <= state_nxt;
            step_r  <= step_nxt;
            fetch_q <= fetch;
            err_r   <= err_nxt;
            strb_r  <= strb_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step_r;
        err_nxt   = err_r;
        strb_nxt  = '0;
        case (state)
            IDLE: begin
                if (rise || !WAIT_FETCH) begin
                    state_nxt = RUN;
                    step_nxt  = 3'd0;
                    strb_nxt  = decode(3'd0, opcode, zero);
                end
            end
            RUN: begin
                // halt is only ever set during step 3 of HLT
                if (strb_r[B_HALT]) begin
                    state_nxt = HALTED;
                    step_nxt  = 3'd0;
                    strb_nxt  = STRB_HALTED;
                end else begin
                    if (rise && (step_r != 3'd7)) begin
                        err_nxt  = 1'b1;
                        step_nxt = RESYNC_EN ? 3'd0 : step_r + 3'd1;
                    end else begin
                        step_nxt = step_r + 3'd1;
                    end
                    strb_nxt = decode(step_nxt, opcode, zero);
                end
            end
            HALTED: begin
                step_nxt = 3'd0;
                strb_nxt = STRB_HALTED;
            end
            default: begin
                state_nxt = IDLE;
                step_nxt  = 3'd0;
            end
        endcase
    end

    assign inc_pc      = strb_r[B_INC_PC];
    assign load_pc     = strb_r[B_LOAD_PC];
    assign load_acc    = strb_r[B_LOAD_ACC];
    assign rd          = strb_r[B_RD];
    assign wr          = strb_r[B_WR];
    assign load_ir     = strb_r[B_LOAD_IR];
    assign datactl_ena = strb_r[B_DATACTL];
    assign halt        = strb_r[B_HALT];
    assign step        = step_r;
    assign running     = (state == RUN);
    assign sync_err    = err_r;

endmodule

// File: tb/tb_machine_ctl.sv
// Directed bench for machine_ctl: per-opcode strobe tables, halt, resync and
// mid-instruction reset, with immediate-assertion checks.
module tb_machine_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch;
    logic [2:0] opcode;
    logic       zero;
    logic       inc_pc, load_pc, load_acc, rd, wr, load_ir, datactl_ena, halt;
    logic [2:0] step;
    logic       running;
    logic       sync_err;

    int checks = 0;
    int errors = 0;
    int ph     = 0;
    bit gen_on = 1'b0;

    logic [7:0] strb;
    assign strb = {inc_pc, load_pc, load_acc, rd, wr, load_ir, datactl_ena, halt};

    machine_ctl dut (
        .clk        (clk),
        .reset      (reset),
        .fetch      (fetch),
        .opcode     (opcode),
        .zero       (zero),
        .inc_pc     (inc_pc),
        .load_pc    (load_pc),
        .load_acc   (load_acc),
        .rd         (rd),
        .wr         (wr),
        .load_ir    (load_ir),
        .datactl_ena(datactl_ena),
        .halt       (halt),
        .step       (step),
        .running    (running),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive fetch from the period-8 generator, sample 1 time unit after the edge
    task automatic tick();
        if (gen_on) begin
            fetch = (ph < 4);
            ph = (ph + 1) % 8;
        end
        @(posedge clk);
        #1;
        chk("wr_rd_excl", {7'b0, wr & rd}, 8'h00);
        chk("ldpc_ldacc_excl", {7'b0, load_pc & load_acc}, 8'h00);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_strobes"}, strb, 8'h00);
        chk({tag, "_step"}, {5'b0, step}, 8'h00);
        chk({tag, "_running"}, {7'b0, running}, 8'h00);
        chk({tag, "_sync_err"}, {7'b0, sync_err}, 8'h00);
    endtask

    // Strobe order {inc_pc, load_pc, load_acc, rd, wr, load_ir, datactl_ena, halt}, step 0 first
    task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                             input logic [63:0] tab);
        opcode = op;
        zero   = z;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk({name, "_step"}, {5'b0, step}, k[7:0]);
            chk({name, "_strobes"}, strb, tab[63-8*k -: 8]);
            chk({name, "_running"}, {7'b0, running}, 8'h01);
            chk({name, "_sync_err"}, {7'b0, sync_err}, 8'h00);
        end
    endtask

    initial begin
        reset  = 1'b1;
        fetch  = 1'b0;
        opcode = 3'd5;
        zero   = 1'b0;
        repeat (3) tick();
        chk_quiet("reset");

        // WAIT_FETCH: no rise yet, stays in IDLE
        reset = 1'b0;
        tick();
        chk_quiet("idle_wait");

        gen_on = 1'b1;
        ph     = 0;
        run_instr("lda0", 3'd5, 1'b0, 64'h14_94_00_80_10_30_10_00);
        run_instr("lda1", 3'd5, 1'b1, 64'h14_94_00_80_10_30_10_00);
        run_instr("sto",  3'd6, 1'b0, 64'h14_94_00_80_02_0A_02_00);
        run_instr("skz1", 3'd1, 1'b1, 64'h14_94_00_80_00_80_00_80);
        run_instr("skz0", 3'd1, 1'b0, 64'h14_94_00_80_00_00_00_00);
        run_instr("jmp",  3'd7, 1'b1, 64'h14_94_00_80_40_C0_00_00);
        run_instr("add",  3'd2, 1'b0, 64'h14_94_00_80_10_30_10_00);

        // HLT: halt with inc_pc at step 3, then HALTED ignoring fetch
        opcode = 3'd0;
        tick(); chk("hlt_s0", strb, 8'h14);
        tick(); chk("hlt_s1", strb, 8'h94);
        tick(); chk("hlt_s2", strb, 8'h00);
        tick(); chk("hlt_s3", strb, 8'h81);
        chk("hlt_s3_step", {5'b0, step}, 8'h03);
        tick();
        chk("halted_strobes", strb, 8'h01);
        chk("halted_step", {5'b0, step}, 8'h00);
        chk("halted_running", {7'b0, running}, 8'h00);
        opcode = 3'd5;
        repeat (16) begin
            tick();
            chk("halted_hold", {running, step, strb[7:4]}, 8'h00);
            chk("halted_hold_halt", strb, 8'h01);
        end
        reset = 1'b1;
        tick();
        chk_quiet("halt_reset");

        // Misaligned rise at step 3 forces step 0 and sets sticky sync_err
        gen_on = 1'b0;
        fetch  = 1'b0;
        tick();
        reset  = 1'b0;
        opcode = 3'd5;
        fetch  = 1'b1;
        tick();
        chk("rs_s0", {5'b0, step}, 8'h00);
        chk("rs_s0_running", {7'b0, running}, 8'h01);
        fetch = 1'b0;
        repeat (3) tick();
        chk("rs_s3", {5'b0, step}, 8'h03);
        chk("rs_s3_err", {7'b0, sync_err}, 8'h00);
        fetch = 1'b1;
        tick();
        chk("rs_resync_step", {5'b0, step}, 8'h00);
        chk("rs_resync_err", {7'b0, sync_err}, 8'h01);
        chk("rs_resync_strobes", strb, 8'h14);
        fetch = 1'b0;
        repeat (7) tick();
        chk("rs_s7", {5'b0, step}, 8'h07);
        chk("rs_err_sticky", {7'b0, sync_err}, 8'h01);

        // Aligned rise at step 7 then reset during JMP step 5
        gen_on = 1'b1;
        ph     = 0;
        opcode = 3'd7;
        repeat (6) tick();
        chk("jmp5_step", {5'b0, step}, 8'h05);
        chk("jmp5_strobes", strb, 8'hC0);
        chk("jmp5_err_held", {7'b0, sync_err}, 8'h01);
        reset = 1'b1;
        tick();
        chk_quiet("mid_reset");
        reset  = 1'b0;
        gen_on = 1'b0;
        fetch  = 1'b0;
        tick();
        chk_quiet("post_reset_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
